// File: rtl/alu_status_unit.sv
// +------------------------------------------------------------------------+
// | Module      : alu_status_unit                                          |
// | Description : ALU status consumer. Registers the status byte, keeps    |
// |               sticky flags and issues a precise exception request with |
// |               an acknowledge timeout to the pipeline control unit.     |
// | Options     : EXC_COUNT_EN adds a saturating exc_count[15:0] output.   |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
`default_nettype none

module alu_status_unit #(
  parameter logic [7:0] EXC_MASK    = 8'b0010_1100,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ALU_valid,
  input  logic [7:0]  ALU_status,
  input  logic [31:0] ALU_result,
  input  logic [31:0] PC_in,
  input  logic        sticky_clr,
  input  logic        exc_ack,
  output logic [7:0]  flags,
  output logic [7:0]  sticky_flags,
  output logic        exc_req,
  output logic [4:0]  exc_cause,
  output logic [31:0] exc_epc,
  output logic [31:0] exc_badval,
  output logic        lost_exc,
  output logic        exc_timeout
`ifdef EXC_COUNT_EN
  ,
  output logic [15:0] exc_count
`endif
);

  localparam int              CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  // Status bits [1:0] carry no meaning and never reach flags/sticky_flags.
  localparam logic [7:0]      FLAG_MASK = 8'hFC;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       flags_q, flags_d;
  logic [7:0]       sticky_q, sticky_d;
  logic [4:0]       cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      badval_q, badval_d;
  logic             lost_q, lost_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       masked;
  logic             hit;
  logic             load;
  logic [4:0]       new_cause;
`ifdef EXC_COUNT_EN
  logic [15:0]      count_q, count_d;
`endif

  // Exception detection and cause encoding: div0 > ovf > misalign.
  always_comb begin
    masked    = ALU_status & EXC_MASK;
    hit       = ALU_valid & (|masked);
    new_cause = 5'd0;
    if (masked[2]) begin
      new_cause = 5'd13;
    end else if (masked[5]) begin
      new_cause = 5'd12;
    end else if (masked[3]) begin
      new_cause = 5'd4;
    end
  end

  // Next-state logic: status registers, sticky bits and the request FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    badval_d  = badval_q;
    load      = 1'b0;
    flags_d   = flags_q;
    sticky_d  = sticky_clr ? 8'h00 : sticky_q;
    lost_d    = sticky_clr ? 1'b0 : lost_q;
    timeout_d = sticky_clr ? 1'b0 : timeout_q;

    if (ALU_valid) begin
      flags_d  = ALU_status & FLAG_MASK;
      sticky_d = sticky_d | (ALU_status & FLAG_MASK);
    end

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          load = 1'b1;
        end
      end
      REQ: begin
        if (exc_ack) begin
          // An ack taking effect in the timeout cycle still counts as an ack.
          if (hit) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            cause_d = 5'd0;
          end
        end else begin
          if (hit) begin
            lost_d = 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cause_d   = 5'd0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d  = REQ;
      cnt_d    = '0;
      cause_d  = new_cause;
      epc_d    = PC_in;
      badval_d = ALU_result;
    end
  end

`ifdef EXC_COUNT_EN
  // Saturating count of loaded exceptions; a clear and a load together give 1.
  always_comb begin
    count_d = sticky_clr ? 16'h0000 : count_q;
    if (load && (count_d != 16'hFFFF)) begin
      count_d = count_d + 16'h0001;
    end
  end
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flags_q   <= 8'h00;
      sticky_q  <= 8'h00;
      cause_q   <= 5'd0;
      epc_q     <= 32'h0;
      badval_q  <= 32'h0;
      lost_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef EXC_COUNT_EN
      count_q   <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      sticky_q  <= sticky_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      badval_q  <= badval_d;
      lost_q    <= lost_d;
      timeout_q <= timeout_d;
`ifdef EXC_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  assign flags        = flags_q;
  assign sticky_flags = sticky_q;
  assign exc_req      = (state_q == REQ);
  assign exc_cause    = cause_q;
  assign exc_epc      = epc_q;
  assign exc_badval   = badval_q;
  assign lost_exc     = lost_q;
  assign exc_timeout  = timeout_q;
`ifdef EXC_COUNT_EN
  assign exc_count    = count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_status_unit.sv
// +------------------------------------------------------------------------+
// | Module      : tb_alu_status_unit                                       |
// | Description : Self-checking bench for alu_status_unit: directed cases  |
// |               followed by random traffic against a reference model.    |
// | Options     : EXC_COUNT_EN also checks exc_count.                      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_alu_status_unit;

  localparam logic [7:0] MASK = 8'b0010_1100;
  localparam int         TMO  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ALU_valid = 1'b0;
  logic [7:0]  ALU_status = 8'h00;
  logic [31:0] ALU_result = 32'h0;
  logic [31:0] PC_in = 32'h0;
  logic        sticky_clr = 1'b0;
  logic        exc_ack = 1'b0;
  logic [7:0]  flags, sticky_flags;
  logic        exc_req;
  logic [4:0]  exc_cause;
  logic [31:0] exc_epc, exc_badval;
  logic        lost_exc, exc_timeout;
`ifdef EXC_COUNT_EN
  logic [15:0] exc_count;
`endif

  int checks = 0;
  int failures = 0;

  // Reference state: a pending exception plus how long it has waited.
  bit          m_pending;
  int          m_age;
  logic [7:0]  m_flags, m_sticky;
  logic [4:0]  m_cause;
  logic [31:0] m_epc, m_bad;
  bit          m_lost, m_to;
  int          m_count;

  alu_status_unit #(.EXC_MASK(MASK), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ALU_valid(ALU_valid), .ALU_status(ALU_status),
    .ALU_result(ALU_result), .PC_in(PC_in), .sticky_clr(sticky_clr),
    .exc_ack(exc_ack), .flags(flags), .sticky_flags(sticky_flags),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_epc(exc_epc),
    .exc_badval(exc_badval), .lost_exc(lost_exc), .exc_timeout(exc_timeout)
`ifdef EXC_COUNT_EN
    , .exc_count(exc_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] cause_of(input logic [7:0] st);
    logic [7:0] m;
    m = st & MASK;
    if (m[2]) return 5'd13;
    if (m[5]) return 5'd12;
    if (m[3]) return 5'd4;
    return 5'd0;
  endfunction

  // Advance the reference by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit hit;
    hit = ALU_valid && ((ALU_status & MASK) != 8'h00);
    if (reset) begin
      m_pending = 0; m_age = 0; m_flags = 0; m_sticky = 0; m_cause = 0;
      m_epc = 0; m_bad = 0; m_lost = 0; m_to = 0; m_count = 0;
      return;
    end
    if (sticky_clr) begin
      m_sticky = 0; m_lost = 0; m_to = 0; m_count = 0;
    end
    if (ALU_valid) begin
      m_flags  = {ALU_status[7:2], 2'b00};
      m_sticky = m_sticky | {ALU_status[7:2], 2'b00};
    end
    if (hit && (!m_pending || exc_ack)) begin
      m_pending = 1; m_age = 0; m_cause = cause_of(ALU_status);
      m_epc = PC_in; m_bad = ALU_result;
      if (m_count < 65535) m_count++;
    end else if (m_pending && exc_ack) begin
      m_pending = 0; m_cause = 0;
    end else if (m_pending) begin
      if (hit) m_lost = 1;
      if (m_age + 1 >= TMO) begin
        m_pending = 0; m_cause = 0; m_to = 1;
      end else begin
        m_age++;
      end
    end
  endtask

  // One cycle: edge, model update, then compare everything just after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("flags", 32'(flags), 32'(m_flags));
    check("sticky", 32'(sticky_flags), 32'(m_sticky));
    check("req", 32'(exc_req), 32'(m_pending));
    check("cause", 32'(exc_cause), 32'(m_cause));
    check("epc", exc_epc, m_epc);
    check("badval", exc_badval, m_bad);
    check("lost", 32'(lost_exc), 32'(m_lost));
    check("timeout", 32'(exc_timeout), 32'(m_to));
`ifdef EXC_COUNT_EN
    check("count", 32'(exc_count), 32'(m_count));
`endif
  endtask

  task automatic drive(input logic v, input logic [7:0] st, input logic [31:0] pc,
                       input logic [31:0] res, input logic ack, input logic clr);
    ALU_valid = v; ALU_status = st; PC_in = pc; ALU_result = res;
    exc_ack = ack; sticky_clr = clr;
  endtask

  initial begin
    int n;
    // Reset state.
    reset = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0);
    step(); step();
    check("rst_flags", 32'(flags), 0);
    check("rst_req", 32'(exc_req), 0);
    reset = 1'b0;

    // Non-exception status only updates flags.
    drive(1, 8'h80, 32'h10, 32'h1, 0, 0); step();
    check("d_flags80", 32'(flags), 32'h80);
    check("d_noreq", 32'(exc_req), 0);

    // div0+ovf: div0 wins; then ack releases.
    drive(1, 8'h24, 32'h40, 32'h7, 0, 0); step();
    check("d_req", 32'(exc_req), 1);
    check("d_cause13", 32'(exc_cause), 13);
    check("d_epc", exc_epc, 32'h40);
    check("d_bad", exc_badval, 32'h7);
    drive(0, 8'h00, 0, 0, 1, 0); step();
    check("d_ackdrop", 32'(exc_req), 0);
    check("d_keepepc", exc_epc, 32'h40);

    // Drop without ack, then back-to-back with ack.
    drive(1, 8'h04, 32'h80, 32'h9, 0, 0); step();
    drive(1, 8'h20, 32'h84, 32'hA, 0, 0); step();
    check("d_lost", 32'(lost_exc), 1);
    check("d_cause_hold", 32'(exc_cause), 13);
    drive(1, 8'h20, 32'h88, 32'hB, 1, 0); step();
    check("d_b2b_req", 32'(exc_req), 1);
    check("d_b2b_cause", 32'(exc_cause), 12);
    check("d_b2b_epc", exc_epc, 32'h88);
    drive(0, 8'h00, 0, 0, 1, 1); step();

    // Timeout: request lasts exactly TMO cycles.
    drive(1, 8'h08, 32'hC0, 32'h3, 0, 0); step();
    check("d_mis_cause", 32'(exc_cause), 4);
    drive(0, 8'h00, 0, 0, 0, 0);
    n = 1;
    while (exc_req && n < 40) begin
      step();
      if (exc_req) n++;
    end
    check("d_to_len", 32'(n), 32'(TMO));
    check("d_to_flag", 32'(exc_timeout), 1);

    // Sticky accumulation and clear with a simultaneous set.
    drive(0, 8'h00, 0, 0, 0, 1); step();
    drive(1, 8'h10, 0, 0, 0, 0); step();
    drive(1, 8'h80, 0, 0, 0, 0); step();
    check("d_sticky90", 32'(sticky_flags), 32'h90);
    drive(1, 8'h40, 0, 0, 0, 1); step();
    check("d_sticky40", 32'(sticky_flags), 32'h40);
    check("d_to_clr", 32'(exc_timeout), 0);

`ifdef EXC_COUNT_EN
    reset = 1'b1; drive(0, 8'h00, 0, 0, 0, 0); step(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'h04, 32'(k), 32'(k), 0, 0); step();
      drive(0, 8'h00, 0, 0, 1, 0); step();
    end
    check("d_count3", 32'(exc_count), 3);
    drive(1, 8'h20, 0, 0, 0, 0); step();
    reset = 1'b1; drive(0, 8'h00, 0, 0, 0, 0); step(); reset = 1'b0;
    check("d_rst_req", 32'(exc_req), 0);
    check("d_rst_count", 32'(exc_count), 0);
`endif

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 1) == 1, 8'($urandom), $urandom, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
